// File: rtl/shift_reg_bank.sv
// WIDTH-bit shift/load register with clock enable, rotate/fill shifts and true/complement outputs.
// Optional: define SYNC_SET_EN to add the synchronous active-low set input s.
module shift_reg_bank #(
  parameter int unsigned     WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             r,
`ifdef SYNC_SET_EN
  input  logic             s,
`endif
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qr,
  output logic             sout,
  output logic             zero
);

  localparam int unsigned MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_HOLD  = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_SHR   = MODE_W'(1);
  localparam logic [MODE_W-1:0] MODE_SHL   = MODE_W'(2);
  localparam logic [MODE_W-1:0] MODE_LOAD  = MODE_W'(3);

  logic [WIDTH-1:0] q_next;
  logic             sout_next;
  logic             set_n;
  logic             fill_r;
  logic             fill_l;

`ifdef SYNC_SET_EN
  assign set_n = s;
`else
  assign set_n = 1'b1;
`endif

  // Bits entering the register on a shift: wrapped-around bit or serial input
  assign fill_r = rot ? Q[0]       : sin_r;
  assign fill_l = rot ? Q[WIDTH-1] : sin_l;

  // Next-state selection: set, then enable, then mode
  always_comb begin
    q_next    = Q;
    sout_next = sout;
    if (!set_n) begin
      q_next    = {WIDTH{1'b1}};
      sout_next = 1'b0;
    end else if (en) begin
      case (mode)
        MODE_SHR: begin
          q_next    = {fill_r, Q[WIDTH-1:1]};
          sout_next = Q[0];
        end
        MODE_SHL: begin
          q_next    = {Q[WIDTH-2:0], fill_l};
          sout_next = Q[WIDTH-1];
        end
        MODE_LOAD: q_next = D;
        MODE_HOLD: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      Q    <= RESET_VAL;
      sout <= 1'b0;
    end else begin
      Q    <= q_next;
      sout <= sout_next;
    end
  end

  assign Qr   = ~Q;
  assign zero = (Q == '0);

endmodule

// File: tb/tb_shift_reg_bank.sv
// Self-checking bench for shift_reg_bank (WIDTH=4): reference model plus directed literal checks.
// Define SYNC_SET_EN for both bench and RTL to exercise the set input.
`timescale 1ns/1ps
module tb_shift_reg_bank;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         r   = 1'b0;
  logic         s   = 1'b1;
  logic         en  = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         rot = 1'b0;
  logic         sin_r = 1'b0;
  logic         sin_l = 1'b0;
  logic [W-1:0] D = '0;
  logic [W-1:0] Q, Qr;
  logic         sout, zero;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  // Model state as plain integers
  int mq = 0;
  int ms = 0;

  shift_reg_bank #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clk(clk), .r(r),
`ifdef SYNC_SET_EN
    .s(s),
`endif
    .en(en), .mode(mode), .rot(rot), .sin_r(sin_r), .sin_l(sin_l),
    .D(D), .Q(Q), .Qr(Qr), .sout(sout), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic on integer state
  always @(posedge clk or negedge r) begin
    int fill;
    if (!r) begin
      mq = 0;
      ms = 0;
    end
`ifdef SYNC_SET_EN
    else if (!s) begin
      mq = MASK;
      ms = 0;
    end
`endif
    else if (en) begin
      if (mode == 2'd1) begin
        fill = rot ? (mq % 2) : int'(sin_r);
        ms   = mq % 2;
        mq   = (mq / 2) + fill * (1 << (W - 1));
      end else if (mode == 2'd2) begin
        fill = rot ? (mq / (1 << (W - 1))) : int'(sin_l);
        ms   = mq / (1 << (W - 1));
        mq   = ((mq * 2) & MASK) + fill;
      end else if (mode == 2'd3) begin
        mq = int'(D);
      end
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model_q",    int'(Q),    mq);
      chk("model_qr",   int'(Qr),   (~mq) & MASK);
      chk("model_sout", int'(sout), ms);
      chk("model_zero", int'(zero), (mq == 0) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    en = 1'b1; mode = 2'b11; D = v;
    step();
  endtask

  initial begin
    run_cmp = 1'b1;
    #2;
    chk("reset_q",    int'(Q),    0);
    chk("reset_qr",   int'(Qr),   15);
    chk("reset_sout", int'(sout), 0);
    chk("reset_zero", int'(zero), 1);
    step();
    r = 1'b1;

    // Mid-cycle asynchronous reset from a non-zero state with sout=1
    load(4'b1011);
    en = 1'b1; mode = 2'b01; rot = 1'b0; sin_r = 1'b0;
    step();
    load(4'b1010);
    chk("pre_rst_q",    int'(Q),    4'b1010);
    chk("pre_rst_sout", int'(sout), 1);
    #2 r = 1'b0;
    #1;
    chk("async_q",    int'(Q),    0);
    chk("async_qr",   int'(Qr),   15);
    chk("async_sout", int'(sout), 0);
    chk("async_zero", int'(zero), 1);
    @(negedge clk);
    #1 r = 1'b1;
    load(4'b0110);
    chk("post_rst_load", int'(Q), 4'b0110);

    // Shift right with serial fill
    load(4'b1001);
    en = 1'b1; mode = 2'b01; rot = 1'b0; sin_r = 1'b1;
    step();
    chk("shr1_q", int'(Q), 4'b1100);
    chk("shr1_sout", int'(sout), 1);
    step();
    chk("shr2_q", int'(Q), 4'b1110);
    chk("shr2_sout", int'(sout), 0);

    // Shift left rotate, full wrap
    load(4'b1000);
    mode = 2'b10; rot = 1'b1; sin_l = 1'b0;
    step();
    chk("rol1_q", int'(Q), 4'b0001);
    chk("rol1_sout", int'(sout), 1);
    repeat (3) step();
    chk("rol4_q", int'(Q), 4'b1000);

    // Enable low holds even in shift mode
    load(4'b0101);
    chk("hold_sout0", int'(sout), 0);
    en = 1'b0; mode = 2'b01; rot = 1'b0; sin_r = 1'b1;
    repeat (3) step();
    chk("en0_q", int'(Q), 4'b0101);
    chk("en0_sout", int'(sout), 0);
    en = 1'b1; mode = 2'b00;
    step();
    chk("mode0_q", int'(Q), 4'b0101);

    // Right rotate and left fill
    mode = 2'b01; rot = 1'b1;
    step();
    chk("ror_q", int'(Q), 4'b1010);
    chk("ror_sout", int'(sout), 1);
    mode = 2'b10; rot = 1'b0; sin_l = 1'b1;
    step();
    chk("shl_fill_q", int'(Q), 4'b0101);
    chk("shl_fill_sout", int'(sout), 1);

    load(4'b0000);
    chk("zero_flag", int'(zero), 1);

    // Mixed stimulus checked by the model
    for (int i = 0; i < 60; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      mode  = 2'($urandom_range(0, 3));
      rot   = 1'($urandom_range(0, 1));
      sin_r = 1'($urandom_range(0, 1));
      sin_l = 1'($urandom_range(0, 1));
      D     = 4'($urandom_range(0, 15));
      step();
    end

`ifdef SYNC_SET_EN
    load(4'b0000);
    s = 1'b0; en = 1'b0; mode = 2'b11; D = 4'b0011;
    step();
    chk("set_q", int'(Q), 4'b1111);
    chk("set_sout", int'(sout), 0);
    r = 1'b0;
    #1;
    chk("rst_over_set", int'(Q), 0);
    step();
    chk("rst_over_set_edge", int'(Q), 0);
    s = 1'b1;
    @(negedge clk);
    #1 r = 1'b1;
    step();
`endif

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/shift_reg_bank.md
# shift_reg_bank

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with clock enable and four operating modes (hold, shift right, shift left, parallel load). Shifts can fill from a serial input or rotate. It keeps the true/complement output pair (Q/Qr) and the active-low asynchronous reset of the single-bit cell. It is the general-purpose storage and serialiser element for later exercises: counters, serial links and LFSR front-ends.

## Interface
Parameters:
- WIDTH, 4, register width in bits (≥2)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q while reset is asserted

Ports:
- clk  input  1  rising-edge clock
- r  input  1  reset; asynchronous, active-low; one clock domain only (clk)
- en  input  1  clock enable; 0 = hold regardless of mode
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- rot  input  1  1 = rotate on shift; 0 = fill from serial input
- sin_r  input  1  serial bit entering the MSB on a shift right (rot=0)
- sin_l  input  1  serial bit entering the LSB on a shift left (rot=0)
- D  input  WIDTH  parallel load data
- Q  output  WIDTH  register contents
- Qr  output  WIDTH  bitwise complement of Q, combinational
- sout  output  1  registered: the bit that left the register on the last shift
- zero  output  1  combinational: 1 when Q == 0

## Operation
- Priority, highest first: r low → set (if compiled in) → en low → mode.
- r low, asynchronous: Q = RESET_VAL, sout = 0. This is immediate, with no clock needed, and is held while r is low.
- en=0 or mode=00: Q and sout hold.
- mode=01, shift right:
  - Q ← {fill, Q[WIDTH-1:1]}, sout ← Q[0].
  - fill = Q[0] if rot=1, else sin_r.
- mode=10, shift left:
  - Q ← {Q[WIDTH-2:0], fill}, sout ← Q[WIDTH-1].
  - fill = Q[WIDTH-1] if rot=1, else sin_l.
- mode=11, load: Q ← D; sout holds.
- Qr = ~Q at all times, including during reset (Qr = ~RESET_VAL).
- zero reflects the current Q and is valid during reset.
- rot, sin_r and sin_l are ignored in hold and load.
- No X propagation: D is sampled only on load.

## Timing
- Every update occurs on the rising edge of clk where en=1, with a latency of 1 cycle from input sampling to Q, and the same for sout.
- Qr and zero follow Q combinationally, with no extra cycle.
- Reset assertion takes effect asynchronously, mid-cycle included.
- On the first rising edge after r returns high, the block operates normally on that edge's inputs.
- Mode changes take effect on the next edge and carry no penalty. Back-to-back shifts shift by one bit per cycle.
- Simultaneous r low and any other input: reset wins.
- Rotation wrap-around: after WIDTH consecutive rotates in one direction, Q equals its starting value.

## Configuration
- SYNC_SET_EN defined: adds input port s (1 bit, synchronous, active-low).
  - On a rising edge with r=1 and s=0: Q ← all ones, sout ← 0.
  - Set overrides en and mode; async reset overrides set.
- SYNC_SET_EN undefined: port s does not exist, and behaviour is exactly as described without the set term.

## Test plan
- Reset: drive r=0 mid-cycle with WIDTH=4 and Q=4'b1010 → Q=0000, Qr=1111, sout=0, zero=1 immediately, without any clock edge. Release r; the next edge loads D=0110 with mode=11 → Q=0110.
- Shift right fill: Q=1001, rot=0, sin_r=1, mode=01, 2 enabled edges → Q=1100 then 1110; sout=1 then 0.
- Shift left rotate: Q=1000, rot=1, mode=10 → Q=0001, sout=1. After 4 edges total, Q=1000 again.
- Enable/hold: Q=0101, en=0, mode=01 for 3 edges → Q=0101 and sout unchanged. Then en=1, mode=00 → still 0101.
- SYNC_SET_EN build: Q=0000, s=0, en=0, mode=11 with D=0011 → next edge Q=1111. Assert r=0 together with s=0 → Q=0000.
